// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decoder
// Brief    : Registered RV32I decoder producing one-hot class vectors and raw
//            register/immediate fields. Define CUSTOM_OP_EN to decode 7'h7F.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_code,
  input  logic        en,
  output logic        invalid_instruction,
  output logic [18:0] alu_op,
  output logic [8:0]  jmp_op,
  output logic [8:0]  mem_op,
  output logic        cust_op,
  output logic [5:0]  csr_op,
  output logic [7:0]  mechie_op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  imm_2531,
  output logic [19:0] imm_1231,
  output logic [11:0] imm_2032
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [18:0] w_alu;
  logic [8:0]  w_jmp;
  logic [8:0]  w_mem;
  logic [5:0]  w_csr;
  logic [7:0]  w_mech;
  logic        w_cust;
  logic        w_none;

  assign w_opcode = instruction_code[6:0];
  assign w_funct3 = instruction_code[14:12];
  assign w_funct7 = instruction_code[31:25];

  always_comb begin
    w_alu  = '0;
    w_jmp  = '0;
    w_mem  = '0;
    w_csr  = '0;
    w_mech = '0;
    w_cust = 1'b0;
    case (w_opcode)
      7'h37: w_alu[0] = 1'b1;
      7'h17: w_alu[1] = 1'b1;
      7'h33: begin
        case (w_funct3)
          3'b000: begin
            if (w_funct7 == 7'h00) w_alu[2] = 1'b1;
            else if (w_funct7 == 7'h20) w_alu[3] = 1'b1;
          end
          3'b001: w_alu[4]  = (w_funct7 == 7'h00);
          3'b010: w_alu[5]  = (w_funct7 == 7'h00);
          3'b011: w_alu[6]  = (w_funct7 == 7'h00);
          3'b100: w_alu[7]  = (w_funct7 == 7'h00);
          3'b101: begin
            if (w_funct7 == 7'h00) w_alu[8] = 1'b1;
            else if (w_funct7 == 7'h20) w_alu[9] = 1'b1;
          end
          3'b110: w_alu[10] = (w_funct7 == 7'h00);
          3'b111: w_alu[11] = (w_funct7 == 7'h00);
        endcase
      end
      7'h13: begin
        // Shift-immediates carry funct7 in the immediate field and are flagged by bit 18
        case (w_funct3)
          3'b000: w_alu[12] = 1'b1;
          3'b001: begin
            if (w_funct7 == 7'h00) begin
              w_alu[4]  = 1'b1;
              w_alu[18] = 1'b1;
            end
          end
          3'b010: w_alu[13] = 1'b1;
          3'b011: w_alu[14] = 1'b1;
          3'b100: w_alu[15] = 1'b1;
          3'b101: begin
            if (w_funct7 == 7'h00) begin
              w_alu[8]  = 1'b1;
              w_alu[18] = 1'b1;
            end else if (w_funct7 == 7'h20) begin
              w_alu[9]  = 1'b1;
              w_alu[18] = 1'b1;
            end
          end
          3'b110: w_alu[16] = 1'b1;
          3'b111: w_alu[17] = 1'b1;
        endcase
      end
      7'h6F: w_jmp[0] = 1'b1;
      7'h67: w_jmp[1] = (w_funct3 == 3'b000);
      7'h63: begin
        case (w_funct3)
          3'b000:  w_jmp[2] = 1'b1;
          3'b001:  w_jmp[3] = 1'b1;
          3'b100:  w_jmp[4] = 1'b1;
          3'b101:  w_jmp[5] = 1'b1;
          3'b110:  w_jmp[6] = 1'b1;
          3'b111:  w_jmp[7] = 1'b1;
          default: ;
        endcase
      end
      7'h03: begin
        case (w_funct3)
          3'b000:  w_mem[0] = 1'b1;
          3'b001:  w_mem[1] = 1'b1;
          3'b010:  w_mem[2] = 1'b1;
          3'b100:  w_mem[3] = 1'b1;
          3'b101:  w_mem[4] = 1'b1;
          default: ;
        endcase
      end
      7'h23: begin
        case (w_funct3)
          3'b000:  w_mem[5] = 1'b1;
          3'b001:  w_mem[6] = 1'b1;
          3'b010:  w_mem[7] = 1'b1;
          default: ;
        endcase
        w_mem[8] = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
      end
      7'h73: begin
        case (w_funct3)
          3'b000: begin
            // Privileged/system words are only legal as exact encodings
            case (instruction_code)
              32'h00000073: w_mech[0] = 1'b1;
              32'h00100073: w_mech[1] = 1'b1;
              32'h30200073: begin
                w_mech[2] = 1'b1;
                w_jmp[8]  = 1'b1;
              end
              32'h10500073: w_mech[3] = 1'b1;
              32'h10200073: w_mech[6] = 1'b1;
              32'h00200073: w_mech[7] = 1'b1;
              default: ;
            endcase
          end
          3'b001:  w_csr[0] = 1'b1;
          3'b010:  w_csr[1] = 1'b1;
          3'b011:  w_csr[2] = 1'b1;
          3'b101:  w_csr[3] = 1'b1;
          3'b110:  w_csr[4] = 1'b1;
          3'b111:  w_csr[5] = 1'b1;
          default: ;
        endcase
      end
      7'h0F: begin
        w_mech[4] = (w_funct3 == 3'b000);
        w_mech[5] = (w_funct3 == 3'b001);
      end
`ifdef CUSTOM_OP_EN
      7'h7F: w_cust = 1'b1;
`endif
      default: ;
    endcase
  end

  assign w_none = ~(|{w_alu, w_jmp, w_mem, w_csr, w_mech, w_cust});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalid_instruction <= 1'b0;
      alu_op    <= '0;
      jmp_op    <= '0;
      mem_op    <= '0;
      cust_op   <= 1'b0;
      csr_op    <= '0;
      mechie_op <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      imm_2531  <= '0;
      imm_1231  <= '0;
      imm_2032  <= '0;
    end else if (en) begin
      invalid_instruction <= w_none;
      alu_op    <= w_alu;
      jmp_op    <= w_jmp;
      mem_op    <= w_mem;
      cust_op   <= w_cust;
      csr_op    <= w_csr;
      mechie_op <= w_mech;
      rd        <= instruction_code[11:7];
      rs1       <= instruction_code[19:15];
      rs2       <= instruction_code[24:20];
      imm_2531  <= instruction_code[31:25];
      imm_1231  <= instruction_code[31:12];
      imm_2032  <= instruction_code[31:20];
    end else begin
      // Field outputs deliberately hold while disabled
      invalid_instruction <= 1'b0;
      alu_op    <= '0;
      jmp_op    <= '0;
      mem_op    <= '0;
      cust_op   <= 1'b0;
      csr_op    <= '0;
      mechie_op <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decoder
// Brief    : Scoreboard bench for instruction_decoder using a mask/match model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instruction_code = '0;
  logic        en = 1'b0;
  logic        invalid_instruction;
  logic [18:0] alu_op;
  logic [8:0]  jmp_op;
  logic [8:0]  mem_op;
  logic        cust_op;
  logic [5:0]  csr_op;
  logic [7:0]  mechie_op;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  imm_2531;
  logic [19:0] imm_1231;
  logic [11:0] imm_2032;

  instruction_decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction_code(instruction_code), .en(en),
    .invalid_instruction(invalid_instruction), .alu_op(alu_op), .jmp_op(jmp_op),
    .mem_op(mem_op), .cust_op(cust_op), .csr_op(csr_op), .mechie_op(mechie_op),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm_2531(imm_2531), .imm_1231(imm_1231),
    .imm_2032(imm_2032)
  );

  always #5 clk = ~clk;

  typedef logic [106:0] vec_t;
  logic [106:0] dut_vec;
  assign dut_vec = {invalid_instruction, alu_op, jmp_op, mem_op, cust_op, csr_op,
                    mechie_op, rd, rs1, rs2, imm_2531, imm_1231, imm_2032};

  // Each rule: word matches when (w & mask) == match; sets bit b of class c
  // (0 alu, 1 jmp, 2 mem, 3 csr, 4 mech, 5 custom)
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          cls;
    int          b;
  } rule_t;
  rule_t rules[$];

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];
  logic [31:0] tag_q[$];
  vec_t last_exp = '0;
  bit   mon_on = 1'b0;
  logic [4:0]  h_rd = '0, h_rs1 = '0, h_rs2 = '0;
  logic [6:0]  h_2531 = '0;
  logic [19:0] h_1231 = '0;
  logic [11:0] h_2032 = '0;

  task automatic add(input logic [31:0] m, input logic [31:0] v, input int c, input int b);
    rule_t r;
    r.mask = m; r.match = v; r.cls = c; r.b = b;
    rules.push_back(r);
  endtask

  task automatic build_rules();
    logic [31:0] alu_r[10];
    logic [31:0] alu_i[6];
    int          alu_ib[6];
    logic [31:0] br[6];
    logic [31:0] ld[5];
    logic [2:0]  csr_f3[6];
    logic [31:0] sys_w[6];
    int          sys_b[6];
    alu_r  = '{32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
               32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033};
    alu_i  = '{32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013};
    alu_ib = '{12, 13, 14, 15, 16, 17};
    br     = '{32'h0063, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063};
    ld     = '{32'h0003, 32'h1003, 32'h2003, 32'h4003, 32'h5003};
    csr_f3 = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    sys_w  = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073, 32'h10200073, 32'h00200073};
    sys_b  = '{0, 1, 2, 3, 6, 7};
    add(32'h7F, 32'h37, 0, 0);
    add(32'h7F, 32'h17, 0, 1);
    for (int i = 0; i < 10; i++) add(32'hFE00707F, alu_r[i], 0, i + 2);
    for (int i = 0; i < 6; i++) add(32'h707F, alu_i[i], 0, alu_ib[i]);
    add(32'hFE00707F, 32'h00001013, 0, 4);  add(32'hFE00707F, 32'h00001013, 0, 18);
    add(32'hFE00707F, 32'h00005013, 0, 8);  add(32'hFE00707F, 32'h00005013, 0, 18);
    add(32'hFE00707F, 32'h40005013, 0, 9);  add(32'hFE00707F, 32'h40005013, 0, 18);
    add(32'h7F, 32'h6F, 1, 0);
    add(32'h707F, 32'h67, 1, 1);
    for (int i = 0; i < 6; i++) add(32'h707F, br[i], 1, i + 2);
    for (int i = 0; i < 5; i++) add(32'h707F, ld[i], 2, i);
    for (int i = 0; i < 3; i++) begin
      add(32'h707F, 32'h23 | (i << 12), 2, i + 5);
      add(32'h707F, 32'h23 | (i << 12), 2, 8);
    end
    for (int i = 0; i < 6; i++) add(32'h707F, 32'h73 | (32'(csr_f3[i]) << 12), 3, i);
    for (int i = 0; i < 6; i++) add(32'hFFFFFFFF, sys_w[i], 4, sys_b[i]);
    add(32'hFFFFFFFF, 32'h30200073, 1, 8);
    add(32'h707F, 32'h000F, 4, 4);
    add(32'h707F, 32'h100F, 4, 5);
`ifdef CUSTOM_OP_EN
    add(32'h7F, 32'h7F, 5, 0);
`endif
  endtask

  function automatic vec_t model(input logic [31:0] w, input logic e);
    logic [18:0] a;
    logic [8:0]  j, m;
    logic [5:0]  c;
    logic [7:0]  s;
    logic        cu, inv;
    a = '0; j = '0; m = '0; c = '0; s = '0; cu = 1'b0;
    foreach (rules[k]) begin
      if ((w & rules[k].mask) == rules[k].match) begin
        case (rules[k].cls)
          0: a[rules[k].b] = 1'b1;
          1: j[rules[k].b] = 1'b1;
          2: m[rules[k].b] = 1'b1;
          3: c[rules[k].b] = 1'b1;
          4: s[rules[k].b] = 1'b1;
          default: cu = 1'b1;
        endcase
      end
    end
    inv = e && ({a, j, m, c, s, cu} == '0);
    if (e) begin
      h_rd = w[11:7]; h_rs1 = w[19:15]; h_rs2 = w[24:20];
      h_2531 = w[31:25]; h_1231 = w[31:12]; h_2032 = w[31:20];
    end else begin
      a = '0; j = '0; m = '0; c = '0; s = '0; cu = 1'b0;
    end
    return {inv, a, j, m, cu, c, s, h_rd, h_rs1, h_rs2, h_2531, h_1231, h_2032};
  endfunction

  task automatic check(input string name, input vec_t got, input vec_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] w, input logic e);
    @(negedge clk);
    instruction_code = w;
    en = e;
    exp_q.push_back(model(w, e));
    tag_q.push_back(w);
  endtask

  // Monitor: one result per issued decode, one edge after it was driven
  always @(posedge clk) begin
    #1;
    if (mon_on && exp_q.size() > 0) begin
      vec_t e;
      logic [31:0] t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      last_exp = e;
      check($sformatf("decode %h", t), dut_vec, e);
    end
  end

  // Outputs must not react to inputs before the next rising edge
  always @(negedge clk) begin
    #2;
    if (mon_on) check("latency hold", dut_vec, last_exp);
  end

  logic [31:0] dir_w[16];
  logic        dir_e[16];

  initial begin
    build_rules();
    #1 rst_n = 1'b0;
    #2 check("async reset", dut_vec, '0);
    @(posedge clk); #1 check("reset held", dut_vec, '0);
    @(negedge clk) rst_n = 1'b1;
    mon_on = 1'b1;

    dir_w = '{32'h00000000, 32'h00000000, 32'h00000797, 32'h02c78793, 32'h07f56513,
              32'h305793f3, 32'h30200073, 32'h1a5000ef, 32'h04079263, 32'h00112623,
              32'h8000007F, 32'h02000033, 32'h00001067, 32'h00004073, 32'h40001013,
              32'h30200173};
    dir_e = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 16; i++) issue(dir_w[i], dir_e[i]);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      int          k;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, rules.size() - 1);
        w = (w & ~rules[k].mask) | rules[k].match;
      end
      issue(w, ($urandom_range(0, 7) != 0));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
    end

    // Reset mid-stream discards the in-flight decode
    mon_on = 1'b0;
    @(negedge clk);
    instruction_code = 32'h00000797;
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("mid reset async", dut_vec, '0);
    @(posedge clk); #1 check("mid reset edge", dut_vec, '0);
    @(negedge clk) rst_n = 1'b1;
    h_rd = '0; h_rs1 = '0; h_rs2 = '0; h_2531 = '0; h_1231 = '0; h_2032 = '0;
    @(posedge clk); #1 check("first after reset", dut_vec, model(32'h00000797, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
